// File: rtl/reg_pair_write_arbiter.sv
// Round-robin arbiter sharing one pair of store registers between NREQ requesters.
// Define REGARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module reg_pair_write_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      wsel,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic [DW-1:0]        d1,
    output logic [DW-1:0]        d2,
    output logic                 st1,
    output logic                 st2,
    output logic                 busy,
    output logic [7:0]           txn_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        STORE,
        DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   cur_idx;
    logic            cur_sel;
    logic [DW-1:0]   cur_data;
    logic [NREQ-1:0] cur_onehot;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic            win_sel;
    logic [DW-1:0]   win_data;

`ifndef REGARB_FIXED_PRIO_EN
    logic [IW-1:0]   rr_ptr;
`endif

    assign cur_onehot = NREQ'(1) << cur_idx;

    // Winner search; the round-robin scan is split into [rr_ptr..NREQ-1] then a wrap pass from 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_sel   = 1'b0;
        win_data  = '0;
`ifndef REGARB_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[k] && (k >= int'(rr_ptr))) begin
                win_found = 1'b1;
                win_idx   = IW'(k);
                win_sel   = wsel[k];
                win_data  = wdata[k*DW +: DW];
            end
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[k]) begin
                win_found = 1'b1;
                win_idx   = IW'(k);
                win_sel   = wsel[k];
                win_data  = wdata[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur_idx  <= '0;
            cur_sel  <= 1'b0;
            cur_data <= '0;
            gnt      <= '0;
            ack      <= '0;
            d1       <= '0;
            d2       <= '0;
            st1      <= 1'b0;
            st2      <= 1'b0;
            busy     <= 1'b0;
            txn_cnt  <= '0;
`ifndef REGARB_FIXED_PRIO_EN
            rr_ptr   <= '0;
`endif
        end else begin
            ack <= '0;
            st1 <= 1'b0;
            st2 <= 1'b0;
            case (state)
                IDLE: begin
                    // The request is committed here; later changes on req/wsel/wdata are ignored.
                    if (win_found) begin
                        cur_idx  <= win_idx;
                        cur_sel  <= win_sel;
                        cur_data <= win_data;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    gnt <= cur_onehot;
                    if (cur_sel) begin
                        d2 <= cur_data;
                    end else begin
                        d1 <= cur_data;
                    end
                    state <= STORE;
                end
                STORE: begin
                    st1   <= ~cur_sel;
                    st2   <= cur_sel;
                    state <= DONE;
                end
                DONE: begin
                    gnt     <= '0;
                    ack     <= cur_onehot;
                    txn_cnt <= txn_cnt + 8'd1;
                    busy    <= 1'b0;
`ifndef REGARB_FIXED_PRIO_EN
                    rr_ptr  <= (int'(cur_idx) == NREQ - 1) ? '0 : cur_idx + IW'(1);
`endif
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_pair_write_arbiter.sv
// Directed bench for reg_pair_write_arbiter (NREQ=2, DW=8).
// Expectations follow REGARB_FIXED_PRIO_EN when it is defined for the build.
module tb_reg_pair_write_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  wsel;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic        st1;
    logic        st2;
    logic        busy;
    logic [7:0]  txn_cnt;

    int checks;
    int errors;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  wsel;
        logic [15:0] wdata;
        logic        scramble;
        logic [1:0]  egnt;
        logic        est1;
        logic        est2;
        logic [7:0]  ed1;
        logic [7:0]  ed2;
    } vec_t;

    vec_t vecs [6];

    reg_pair_write_arbiter #(.NREQ(2), .DW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wsel    (wsel),
        .wdata   (wdata),
        .gnt     (gnt),
        .ack     (ack),
        .d1      (d1),
        .d2      (d2),
        .st1     (st1),
        .st2     (st2),
        .busy    (busy),
        .txn_cnt (txn_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] s, input logic [15:0] d);
        req   = r;
        wsel  = s;
        wdata = d;
    endtask

    task automatic doReset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " gnt"}, 32'(gnt), 32'd0);
        checkOutput({tag, " ack"}, 32'(ack), 32'd0);
        checkOutput({tag, " st1"}, 32'(st1), 32'd0);
        checkOutput({tag, " st2"}, 32'(st2), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " txn_cnt"}, 32'(txn_cnt), 32'd0);
        checkOutput({tag, " d1"}, 32'(d1), 32'd0);
        checkOutput({tag, " d2"}, 32'(d2), 32'd0);
    endtask

    // One complete transaction: sampled at edge N, gnt N+1, strobe N+2, ack N+3.
    task automatic runVector(input vec_t v, input int i, input logic [7:0] etxn);
        applyStimulus(v.req, v.wsel, v.wdata);
        tick();
        checkOutput($sformatf("v%0d busy@N", i), 32'(busy), 32'd1);
        checkOutput($sformatf("v%0d gnt@N", i), 32'(gnt), 32'd0);
        if (v.scramble) applyStimulus(2'b00, ~v.wsel, ~v.wdata);
        tick();
        checkOutput($sformatf("v%0d gnt@N+1", i), 32'(gnt), 32'(v.egnt));
        checkOutput($sformatf("v%0d st1@N+1", i), 32'(st1), 32'd0);
        tick();
        checkOutput($sformatf("v%0d gnt@N+2", i), 32'(gnt), 32'(v.egnt));
        checkOutput($sformatf("v%0d st1@N+2", i), 32'(st1), 32'(v.est1));
        checkOutput($sformatf("v%0d st2@N+2", i), 32'(st2), 32'(v.est2));
        checkOutput($sformatf("v%0d d1@N+2", i), 32'(d1), 32'(v.ed1));
        checkOutput($sformatf("v%0d d2@N+2", i), 32'(d2), 32'(v.ed2));
        checkOutput($sformatf("v%0d ack@N+2", i), 32'(ack), 32'd0);
        tick();
        checkOutput($sformatf("v%0d ack@N+3", i), 32'(ack), 32'(v.egnt));
        checkOutput($sformatf("v%0d gnt@N+3", i), 32'(gnt), 32'd0);
        checkOutput($sformatf("v%0d st@N+3", i), 32'({st1, st2}), 32'd0);
        checkOutput($sformatf("v%0d busy@N+3", i), 32'(busy), 32'd0);
        checkOutput($sformatf("v%0d txn_cnt", i), 32'(txn_cnt), 32'(etxn));
        req = 2'b00;
    endtask

    initial begin
        logic [1:0] eack;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        applyStimulus(2'b00, 2'b00, 16'h0000);

        vecs[0] = '{2'b01, 2'b00, 16'h00B5, 1'b0, 2'b01, 1'b1, 1'b0, 8'hB5, 8'h00};
        vecs[1] = '{2'b10, 2'b10, 16'h3C00, 1'b0, 2'b10, 1'b0, 1'b1, 8'hB5, 8'h3C};
        vecs[2] = '{2'b11, 2'b11, 16'hC35A, 1'b1, 2'b01, 1'b0, 1'b1, 8'hB5, 8'h5A};
`ifdef REGARB_FIXED_PRIO_EN
        vecs[3] = '{2'b11, 2'b00, 16'h7711, 1'b0, 2'b01, 1'b1, 1'b0, 8'h11, 8'h5A};
`else
        vecs[3] = '{2'b11, 2'b00, 16'h7711, 1'b0, 2'b10, 1'b1, 1'b0, 8'h77, 8'h5A};
`endif
        vecs[4] = '{2'b10, 2'b01, 16'hE1FF, 1'b0, 2'b10, 1'b1, 1'b0, 8'hE1, 8'h5A};
        vecs[5] = '{2'b01, 2'b11, 16'h009D, 1'b0, 2'b01, 1'b0, 1'b1, 8'hE1, 8'h9D};

        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            runVector(vecs[i], i, 8'(i + 1));
        end

        // Mid-cycle reset while idle with both requests pending.
        applyStimulus(2'b11, 2'b00, 16'h2211);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("async reset");
        #1;
        rst = 1'b0;
        tick();
        tick();
        checkOutput("post-reset first gnt", 32'(gnt), 32'h1);
        tick();
        checkOutput("post-reset d1", 32'(d1), 32'h11);
        tick();
        checkOutput("post-reset ack", 32'(ack), 32'h1);
        checkOutput("post-reset txn_cnt", 32'(txn_cnt), 32'd1);
        req = 2'b00;

        // Two requesters, each dropping its request on its own ack.
        tick();
        doReset();
        applyStimulus(2'b11, 2'b10, 16'hF0A1);
        tick();
        tick();
        tick();
        checkOutput("pair st1", 32'(st1), 32'd1);
        checkOutput("pair d1", 32'(d1), 32'hA1);
        tick();
        checkOutput("pair ack0", 32'(ack), 32'h1);
        req = 2'b10;
        tick();
        tick();
        tick();
        checkOutput("pair st2", 32'(st2), 32'd1);
        checkOutput("pair st1 off", 32'(st1), 32'd0);
        checkOutput("pair d2", 32'(d2), 32'hF0);
        checkOutput("pair d1 kept", 32'(d1), 32'hA1);
        tick();
        checkOutput("pair ack1", 32'(ack), 32'h2);
        checkOutput("pair txn_cnt", 32'(txn_cnt), 32'd2);
        req = 2'b00;

        // Both requests held for 16 cycles, ack ignored.
        tick();
        doReset();
        applyStimulus(2'b11, 2'b00, 16'h4433);
        for (int t = 0; t < 16; t++) begin
            tick();
            if (t % 4 == 3) begin
`ifdef REGARB_FIXED_PRIO_EN
                eack = 2'b01;
`else
                eack = ((t / 4) % 2 == 0) ? 2'b01 : 2'b10;
`endif
            end else begin
                eack = 2'b00;
            end
            checkOutput($sformatf("held ack t%0d", t), 32'(ack), 32'(eack));
        end
        checkOutput("held txn_cnt", 32'(txn_cnt), 32'd4);
        req = 2'b00;

        // Reset during the strobe cycle aborts the write.
        tick();
        doReset();
        applyStimulus(2'b01, 2'b00, 16'h0042);
        tick();
        tick();
        tick();
        checkOutput("abort st1 before", 32'(st1), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort st1 dropped", 32'(st1), 32'd0);
        checkOutput("abort gnt", 32'(gnt), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        req = 2'b00;
        #1;
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            checkOutput($sformatf("abort ack t%0d", t), 32'(ack), 32'd0);
            checkOutput($sformatf("abort busy t%0d", t), 32'(busy), 32'd0);
        end
        checkOutput("abort txn_cnt", 32'(txn_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_pair_write_arbiter.md
Name: reg_pair_write_arbiter

Overview:
Shares one pair of 8-bit store registers (two data inputs, per-register store strobes) between NREQ independent requesters. Each requester asks to write one data word into register 1 or register 2. A round-robin FSM serialises these requests and drives the pair's data and store lines. It sits between the requesting logic and the register pair and is the only driver of the pair's inputs.

Parameters:
NREQ, 2, number of requesters (2..8)
DW, 8, data width of each register and of each requester's data word

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester write request; level, held until ack
wsel  input  NREQ  per-requester target: 0 = register 1, 1 = register 2
wdata  input  NREQ*DW  per-requester data; requester i owns bits [i*DW +: DW]
gnt  output  NREQ  one-hot; high for the winner during GRANT and STORE
ack  output  NREQ  one-cycle completion pulse to the winner
d1  output  DW  data to register 1
d2  output  DW  data to register 2
st1  output  1  store strobe for register 1, one cycle
st2  output  1  store strobe for register 2, one cycle
busy  output  1  high in every state except IDLE
txn_cnt  output  8  completed-write count, wraps 255 -> 0

Behaviour:
- Reset (asynchronous, takes effect immediately, any state):
  - state = IDLE, rr_ptr = 0.
  - gnt, ack, st1, st2, busy, txn_cnt, d1, d2 all = 0.
- All outputs are registered.
- FSM states: IDLE -> GRANT -> STORE -> DONE -> IDLE. Each non-IDLE state lasts exactly one cycle.
- IDLE:
  - If req is nonzero, pick the winner: the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Latch the winner index, its wsel bit and its wdata slice, then go to GRANT.
  - If req is zero, stay in IDLE.
- GRANT:
  - gnt[winner] = 1.
  - Latched data is driven on d1 (wsel = 0) or on d2 (wsel = 1).
  - Go to STORE.
- STORE:
  - gnt stays high and data stays driven.
  - st1 or st2 = 1, matching the latched wsel. Never both at once.
  - Go to DONE.
- DONE:
  - gnt = 0, ack[winner] = 1.
  - txn_cnt increments.
  - rr_ptr = (winner + 1) mod NREQ.
  - Go to IDLE.
- Latency: req seen high at edge N gives gnt at N+1, st at N+2, ack at N+3. Peak throughput is one write per 4 cycles.
- d1 and d2 hold their last driven value outside GRANT/STORE. The register that was not selected keeps its previous value.
- Once latched, a request is committed:
  - Dropping req or changing wsel/wdata after the IDLE sample has no effect on the transaction.
  - ack is still issued.
- A req still high in the IDLE cycle after DONE is arbitrated again as a new request. Requesters must drop req on ack to avoid a duplicate write.
- Simultaneous requests: exactly one winner per the rotating scan. Losers wait with no gnt or ack.
- Reset during GRANT/STORE/DONE aborts the transaction: no strobe or ack follows, and txn_cnt is not incremented.
- Only requester indices below NREQ are meaningful.

Optional Feature:
Macro REGARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index active req always wins, rr_ptr is neither used nor updated, and starvation is permitted.
- Undefined (default): round-robin as described above.

Test Plan:
1. rst=1 pulsed mid-cycle while idle, with req=2'b11 -> all outputs 0 immediately; after release, requester 0 is served first.
2. NREQ=2; req=2'b01, wsel=2'b00, wdata[7:0]=8'b10110101 held until ack -> gnt=01 at N+1; st1=1 with d1=8'b10110101 at N+2; st2=0; ack=01 at N+3; txn_cnt=1; d2 stays 0.
3. From reset: req=2'b11, wsel=2'b10, wdata={8'b11110000, 8'b10100001}, each requester drops req on its ack -> st1 with d1=8'b10100001 and ack=01 first; 4 cycles later st2 with d2=8'b11110000 and ack=10; txn_cnt=2.
4. Both req held high for 16 cycles, ignoring ack -> acks alternate 01,10,01,10 every 4 cycles; txn_cnt=4.
5. Single write; rst asserted during the STORE cycle -> st1 drops immediately; no ack; txn_cnt=0; state IDLE.
6. With REGARB_FIXED_PRIO_EN, both req held high for 16 cycles -> ack=01 four times, requester 1 never granted; txn_cnt=4.
